// File: rtl/sdram_req_arb_if.sv
// Request/ack handshake and FIFO-level bus between the burst arbiter and the
// SDRAM controller / FIFO side.
interface sdram_req_arb_if #(
  parameter int FIFO_AW = 10,
  parameter int ADDR_W  = 15
);
  logic [FIFO_AW:0]  wr_fifo_usedw;
  logic [FIFO_AW:0]  rd_fifo_usedw;
  logic              wr_sdram_req;
  logic              rd_sdram_req;
  logic              wr_sdram_ack;
  logic              rd_sdram_ack;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  modport master (
    input  wr_fifo_usedw, rd_fifo_usedw, wr_sdram_ack, rd_sdram_ack,
    output wr_sdram_req, rd_sdram_req, wr_addr, rd_addr
  );

  modport slave (
    output wr_fifo_usedw, rd_fifo_usedw, wr_sdram_ack, rd_sdram_ack,
    input  wr_sdram_req, rd_sdram_req, wr_addr, rd_addr
  );
endinterface

// File: rtl/sdram_req_arb.sv
// Upstream burst arbiter for the SDRAM controller: picks the next full-page
// read or write burst from FIFO levels and tracks per-burst frame addresses.
module sdram_req_arb #(
  parameter int BURST_LEN    = 512,
  parameter int FIFO_AW      = 10,
  parameter int FRAME_BURSTS = 600,
  parameter int ADDR_W       = 15,
  parameter int GAP_CYC      = 16,
  parameter int TIMEOUT      = 4095
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_done,
  input  logic                  frame_sync,
  sdram_req_arb_if.master       bus,
  output logic                  wr_done,
  output logic                  err_timeout
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR_BUSY = 2'd1;
  localparam logic [1:0] RD_BUSY = 2'd2;
  localparam logic [1:0] GAP     = 2'd3;

  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [FIFO_AW:0]  BURST_LVL  = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [FIFO_AW:0]  RD_ROOM    = (FIFO_AW+1)'((1 << FIFO_AW) - BURST_LEN);
  localparam logic [ADDR_W-1:0] LAST_BURST = ADDR_W'(FRAME_BURSTS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_CYC - 1);
  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT - 1);

  logic [1:0]        state_r;
  logic              wr_req_r;
  logic              rd_req_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              wr_done_r;
  logic              err_timeout_r;
  logic              fs_pend_r;
  logic [GAP_W-1:0]  gap_cnt_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic              wr_ok_s;
  logic              rd_ok_s;

  // Burst eligibility; only consulted while idle.
  always_comb begin
    wr_ok_s = init_done & ~wr_done_r & (bus.wr_fifo_usedw >= BURST_LVL);
    rd_ok_s = init_done & (bus.rd_fifo_usedw <= RD_ROOM) &
              (wr_done_r | (rd_addr_r < wr_addr_r));
  end

  // Arbiter FSM with request, address, gap and timeout bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      wr_req_r      <= 1'b0;
      rd_req_r      <= 1'b0;
      wr_addr_r     <= {ADDR_W{1'b0}};
      rd_addr_r     <= {ADDR_W{1'b0}};
      wr_done_r     <= 1'b0;
      err_timeout_r <= 1'b0;
      fs_pend_r     <= 1'b0;
      gap_cnt_r     <= {GAP_W{1'b0}};
      to_cnt_r      <= {TO_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          gap_cnt_r <= {GAP_W{1'b0}};
          to_cnt_r  <= {TO_W{1'b0}};
          fs_pend_r <= 1'b0;
          if (frame_sync) begin
            rd_addr_r <= {ADDR_W{1'b0}};
          end
          // Read wins ties so the display never starves.
          if (rd_ok_s) begin
            state_r  <= RD_BUSY;
            rd_req_r <= 1'b1;
          end else if (wr_ok_s) begin
            state_r  <= WR_BUSY;
            wr_req_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end

        WR_BUSY: begin
          if (frame_sync) begin
            rd_addr_r <= {ADDR_W{1'b0}};
          end
          if (bus.wr_sdram_ack) begin
            wr_req_r <= 1'b0;
            state_r  <= GAP;
            if (wr_addr_r == LAST_BURST) begin
              wr_addr_r <= {ADDR_W{1'b0}};
              wr_done_r <= 1'b1;
            end else begin
              wr_addr_r <= wr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end else if (to_cnt_r == TO_LAST) begin
            wr_req_r      <= 1'b0;
            err_timeout_r <= 1'b1;
            state_r       <= GAP;
          end else begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
          end
        end

        RD_BUSY: begin
          // A frame start seen mid-burst is applied when the burst ends.
          if (bus.rd_sdram_ack) begin
            rd_req_r  <= 1'b0;
            state_r   <= GAP;
            fs_pend_r <= 1'b0;
            if (frame_sync || fs_pend_r) begin
              rd_addr_r <= {ADDR_W{1'b0}};
            end else if (rd_addr_r == LAST_BURST) begin
              rd_addr_r <= {ADDR_W{1'b0}};
            end else begin
              rd_addr_r <= rd_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end else if (to_cnt_r == TO_LAST) begin
            rd_req_r      <= 1'b0;
            err_timeout_r <= 1'b1;
            state_r       <= GAP;
            fs_pend_r     <= 1'b0;
            if (frame_sync || fs_pend_r) begin
              rd_addr_r <= {ADDR_W{1'b0}};
            end
          end else begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
            if (frame_sync) begin
              fs_pend_r <= 1'b1;
            end
          end
        end

        GAP: begin
          to_cnt_r <= {TO_W{1'b0}};
          if (frame_sync) begin
            rd_addr_r <= {ADDR_W{1'b0}};
          end
          if (gap_cnt_r == GAP_LAST) begin
            gap_cnt_r <= {GAP_W{1'b0}};
            state_r   <= IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
          end
        end

        default: begin
          state_r  <= IDLE;
          wr_req_r <= 1'b0;
          rd_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_sdram_req = wr_req_r;
  assign bus.rd_sdram_req = rd_req_r;
  assign bus.wr_addr      = wr_addr_r;
  assign bus.rd_addr      = rd_addr_r;
  assign wr_done          = wr_done_r;
  assign err_timeout      = err_timeout_r;

endmodule

// File: tb/tb_sdram_req_arb.sv
// Scoreboard bench for sdram_req_arb: expected bursts are queued as stimulus
// is set up and popped when the arbiter raises a request.
module tb_sdram_req_arb;
  logic clk = 1'b0;
  logic rst;
  logic init_done;
  logic frame_sync;
  logic wr_done;
  logic err_timeout;

  sdram_req_arb_if #(.FIFO_AW(10), .ADDR_W(15)) bus ();

  sdram_req_arb dut (
    .clk(clk), .rst(rst), .init_done(init_done), .frame_sync(frame_sync),
    .bus(bus), .wr_done(wr_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic is_rd; logic [14:0] addr; } exp_t;
  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int exp_wr = 0;
  int exp_rd = 0;

  task automatic wait_req(input int limit, output logic got, output logic is_rd,
                          output logic [14:0] addr, output int cyc);
    got = 1'b0; is_rd = 1'b0; addr = 15'd0; cyc = 0;
    while (!got && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (bus.rd_sdram_req || bus.wr_sdram_req) begin
        got   = 1'b1;
        is_rd = bus.rd_sdram_req;
        addr  = bus.rd_sdram_req ? bus.rd_addr : bus.wr_addr;
      end
    end
  endtask

  task automatic pulse_ack(input logic is_rd);
    if (is_rd) bus.rd_sdram_ack = 1'b1;
    else       bus.wr_sdram_ack = 1'b1;
    @(negedge clk);
    bus.rd_sdram_ack = 1'b0;
    bus.wr_sdram_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; init_done = 1'b0; frame_sync = 1'b0;
    bus.wr_fifo_usedw = 11'd0; bus.rd_fifo_usedw = 11'd0;
    bus.wr_sdram_ack = 1'b0; bus.rd_sdram_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.wr_sdram_req !== 1'b0) begin bad++; $display("FAIL reset_wr_req got=%b want=0", bus.wr_sdram_req); end
    total++; if (bus.rd_sdram_req !== 1'b0) begin bad++; $display("FAIL reset_rd_req got=%b want=0", bus.rd_sdram_req); end
    total++; if (bus.wr_addr !== 15'd0) begin bad++; $display("FAIL reset_wr_addr got=%0d want=0", bus.wr_addr); end
    total++; if (bus.rd_addr !== 15'd0) begin bad++; $display("FAIL reset_rd_addr got=%0d want=0", bus.rd_addr); end
    total++; if ({wr_done, err_timeout} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {wr_done, err_timeout}); end
  endtask

  task automatic test_no_init();
    int hits = 0;
    bus.wr_fifo_usedw = 11'd1024;
    repeat (10000) begin
      @(negedge clk);
      if (bus.wr_sdram_req || bus.rd_sdram_req) hits++;
    end
    total++; if (hits !== 0) begin bad++; $display("FAIL no_init_req got=%0d cycles want=0", hits); end
  endtask

  task automatic test_first_write();
    logic got, is_rd; logic [14:0] addr; int cyc; exp_t e;
    init_done = 1'b1;
    bus.wr_fifo_usedw = 11'd512;
    bus.rd_fifo_usedw = 11'd0;
    exp_q.push_back('{is_rd: 1'b0, addr: 15'(exp_wr)});
    wait_req(50, got, is_rd, addr, cyc);
    e = exp_q.pop_front();
    total++; if (!got || is_rd !== e.is_rd || addr !== e.addr) begin bad++; $display("FAIL first_write got=%b/%b/%0d want=1/%b/%0d", got, is_rd, addr, e.is_rd, e.addr); end
    pulse_ack(1'b0);
    exp_wr = 1;
    total++; if (bus.wr_sdram_req !== 1'b0) begin bad++; $display("FAIL first_write_drop got=%b want=0", bus.wr_sdram_req); end
    total++; if (bus.wr_addr !== 15'(exp_wr)) begin bad++; $display("FAIL first_write_addr got=%0d want=%0d", bus.wr_addr, exp_wr); end
    // rd_addr 0 < wr_addr 1 now, so a read is next
    exp_q.push_back('{is_rd: 1'b1, addr: 15'(exp_rd)});
    wait_req(100, got, is_rd, addr, cyc);
    e = exp_q.pop_front();
    total++; if (cyc + 1 < 17) begin bad++; $display("FAIL gap_len got=%0d want>=17", cyc + 1); end
    total++; if (!got || is_rd !== e.is_rd || addr !== e.addr) begin bad++; $display("FAIL first_read got=%b/%b/%0d want=1/%b/%0d", got, is_rd, addr, e.is_rd, e.addr); end
    pulse_ack(1'b1);
    exp_rd = 1;
    total++; if (bus.rd_addr !== 15'(exp_rd)) begin bad++; $display("FAIL first_read_addr got=%0d want=%0d", bus.rd_addr, exp_rd); end
  endtask

  task automatic test_read_priority();
    logic got, is_rd; logic [14:0] addr; int cyc; exp_t e;
    bus.rd_fifo_usedw = 11'd1024;
    bus.wr_fifo_usedw = 11'd600;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{is_rd: 1'b0, addr: 15'(exp_wr)});
      wait_req(100, got, is_rd, addr, cyc);
      e = exp_q.pop_front();
      total++; if (!got || is_rd !== e.is_rd || addr !== e.addr) begin bad++; $display("FAIL prio_fill got=%b/%b/%0d want=1/%b/%0d", got, is_rd, addr, e.is_rd, e.addr); end
      pulse_ack(1'b0);
      exp_wr++;
    end
    bus.rd_fifo_usedw = 11'd100;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{is_rd: 1'b1, addr: 15'(exp_rd)});
      wait_req(100, got, is_rd, addr, cyc);
      e = exp_q.pop_front();
      total++; if (!got || is_rd !== e.is_rd || addr !== e.addr || bus.wr_sdram_req !== 1'b0) begin bad++; $display("FAIL prio_read got=%b/%b/%0d wr_req=%b want=1/%b/%0d wr_req=0", got, is_rd, addr, bus.wr_sdram_req, e.is_rd, e.addr); end
      if (i == 1) bus.rd_fifo_usedw = 11'd1024;
      pulse_ack(1'b1);
      exp_rd++;
    end
    total++; if (bus.rd_addr !== 15'(exp_rd)) begin bad++; $display("FAIL prio_rd_addr got=%0d want=%0d", bus.rd_addr, exp_rd); end
    exp_q.push_back('{is_rd: 1'b0, addr: 15'(exp_wr)});
    wait_req(100, got, is_rd, addr, cyc);
    e = exp_q.pop_front();
    total++; if (!got || is_rd !== e.is_rd || addr !== e.addr || cyc + 1 < 17) begin bad++; $display("FAIL prio_write_after got=%b/%b/%0d gap=%0d want=1/%b/%0d gap>=17", got, is_rd, addr, cyc + 1, e.is_rd, e.addr); end
    pulse_ack(1'b0);
    exp_wr++;
  endtask

  task automatic test_frame_write();
    logic got, is_rd; logic [14:0] addr; int cyc; exp_t e; int hits = 0;
    logic exp_done = 1'b0;
    bus.rd_fifo_usedw = 11'd1024;
    bus.wr_fifo_usedw = 11'd1024;
    while (!exp_done) begin
      exp_q.push_back('{is_rd: 1'b0, addr: 15'(exp_wr)});
      wait_req(100, got, is_rd, addr, cyc);
      e = exp_q.pop_front();
      total++;
      if (!got || is_rd !== e.is_rd || addr !== e.addr || wr_done !== 1'b0) begin
        bad++; $display("FAIL frame_write got=%b/%b/%0d done=%b want=1/%b/%0d done=0", got, is_rd, addr, wr_done, e.is_rd, e.addr);
        break;
      end
      pulse_ack(1'b0);
      if (exp_wr == 599) begin exp_wr = 0; exp_done = 1'b1; end
      else exp_wr++;
    end
    total++; if (wr_done !== 1'b1 || bus.wr_addr !== 15'd0) begin bad++; $display("FAIL frame_done got=%b/%0d want=1/0", wr_done, bus.wr_addr); end
    repeat (100) begin
      @(negedge clk);
      if (bus.wr_sdram_req) hits++;
    end
    total++; if (hits !== 0) begin bad++; $display("FAIL write_after_done got=%0d want=0", hits); end
  endtask

  task automatic test_read_wrap();
    logic got, is_rd; logic [14:0] addr; int cyc; exp_t e;
    logic wrapped = 1'b0;
    bus.rd_fifo_usedw = 11'd0;
    while (!wrapped) begin
      exp_q.push_back('{is_rd: 1'b1, addr: 15'(exp_rd)});
      wait_req(100, got, is_rd, addr, cyc);
      e = exp_q.pop_front();
      total++;
      if (!got || is_rd !== e.is_rd || addr !== e.addr || bus.wr_sdram_req !== 1'b0) begin
        bad++; $display("FAIL read_seq got=%b/%b/%0d wr_req=%b want=1/%b/%0d wr_req=0", got, is_rd, addr, bus.wr_sdram_req, e.is_rd, e.addr);
        break;
      end
      pulse_ack(1'b1);
      if (exp_rd == 599) begin exp_rd = 0; wrapped = 1'b1; end
      else exp_rd++;
    end
    total++; if (bus.rd_addr !== 15'd0) begin bad++; $display("FAIL read_wrap got=%0d want=0", bus.rd_addr); end
  endtask

  task automatic test_frame_sync();
    logic got, is_rd; logic [14:0] addr; int cyc; exp_t e;
    for (int i = 0; i < 41; i++) begin
      exp_q.push_back('{is_rd: 1'b1, addr: 15'(exp_rd)});
      wait_req(100, got, is_rd, addr, cyc);
      e = exp_q.pop_front();
      if (!got || is_rd !== e.is_rd || addr !== e.addr) begin
        total++; bad++; $display("FAIL fs_walk got=%b/%b/%0d want=1/%b/%0d", got, is_rd, addr, e.is_rd, e.addr);
        break;
      end
      if (i < 40) begin pulse_ack(1'b1); exp_rd++; end
    end
    // wrong-type ack while reading at 40
    pulse_ack(1'b0);
    total++; if (bus.rd_sdram_req !== 1'b1 || bus.rd_addr !== 15'd40 || bus.wr_addr !== 15'd0) begin bad++; $display("FAIL wrong_ack got=%b/%0d/%0d want=1/40/0", bus.rd_sdram_req, bus.rd_addr, bus.wr_addr); end
    frame_sync = 1'b1; @(negedge clk); frame_sync = 1'b0;
    @(negedge clk);
    total++; if (bus.rd_addr !== 15'd40) begin bad++; $display("FAIL fs_deferred got=%0d want=40", bus.rd_addr); end
    pulse_ack(1'b1);
    exp_rd = 0;
    total++; if (bus.rd_addr !== 15'd0) begin bad++; $display("FAIL fs_at_ack got=%0d want=0", bus.rd_addr); end
    exp_q.push_back('{is_rd: 1'b1, addr: 15'd0});
    exp_q.push_back('{is_rd: 1'b1, addr: 15'd1});
    for (int i = 0; i < 2; i++) begin
      wait_req(100, got, is_rd, addr, cyc);
      e = exp_q.pop_front();
      total++; if (!got || is_rd !== e.is_rd || addr !== e.addr) begin bad++; $display("FAIL fs_next got=%b/%b/%0d want=1/%b/%0d", got, is_rd, addr, e.is_rd, e.addr); end
      if (i == 1) begin
        frame_sync = 1'b1; bus.rd_sdram_ack = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0; bus.rd_sdram_ack = 1'b0;
      end else begin
        pulse_ack(1'b1);
      end
    end
    total++; if (bus.rd_addr !== 15'd0) begin bad++; $display("FAIL fs_with_ack got=%0d want=0", bus.rd_addr); end
    exp_q.push_back('{is_rd: 1'b1, addr: 15'd0});
    wait_req(100, got, is_rd, addr, cyc);
    e = exp_q.pop_front();
    total++; if (!got || is_rd !== e.is_rd || addr !== e.addr) begin bad++; $display("FAIL fs_pre_idle got=%b/%b/%0d want=1/%b/%0d", got, is_rd, addr, e.is_rd, e.addr); end
    bus.rd_fifo_usedw = 11'd1024;
    pulse_ack(1'b1);
    total++; if (bus.rd_addr !== 15'd1) begin bad++; $display("FAIL fs_pre_idle_addr got=%0d want=1", bus.rd_addr); end
    repeat (30) @(negedge clk);
    frame_sync = 1'b1; @(negedge clk); frame_sync = 1'b0;
    total++; if (bus.rd_addr !== 15'd0) begin bad++; $display("FAIL fs_idle got=%0d want=0", bus.rd_addr); end
  endtask

  task automatic test_timeout();
    logic got, is_rd; logic [14:0] addr; int cyc; exp_t e; int hi;
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL err_before got=%b want=0", err_timeout); end
    bus.rd_fifo_usedw = 11'd0;
    exp_q.push_back('{is_rd: 1'b1, addr: 15'd0});
    wait_req(100, got, is_rd, addr, cyc);
    e = exp_q.pop_front();
    total++; if (!got || is_rd !== e.is_rd || addr !== e.addr) begin bad++; $display("FAIL to_req got=%b/%b/%0d want=1/%b/%0d", got, is_rd, addr, e.is_rd, e.addr); end
    hi = 1;
    while (bus.rd_sdram_req && hi < 5000) begin
      @(negedge clk);
      if (bus.rd_sdram_req) hi++;
    end
    total++; if (hi !== 4095) begin bad++; $display("FAIL to_len got=%0d want=4095", hi); end
    total++; if (err_timeout !== 1'b1 || bus.rd_addr !== 15'd0) begin bad++; $display("FAIL to_flag got=%b/%0d want=1/0", err_timeout, bus.rd_addr); end
    exp_q.push_back('{is_rd: 1'b1, addr: 15'd0});
    wait_req(100, got, is_rd, addr, cyc);
    e = exp_q.pop_front();
    total++; if (!got || is_rd !== e.is_rd || addr !== e.addr || cyc + 1 < 17) begin bad++; $display("FAIL to_retry got=%b/%b/%0d gap=%0d want=1/%b/%0d gap>=17", got, is_rd, addr, cyc + 1, e.is_rd, e.addr); end
    // asynchronous reset between clock edges while the request is up
    #2 rst = 1'b1;
    #1;
    total++; if ({bus.rd_sdram_req, bus.wr_sdram_req, err_timeout, wr_done} !== 4'b0000 || bus.rd_addr !== 15'd0 || bus.wr_addr !== 15'd0) begin bad++; $display("FAIL async_rst got=%b%b%b%b/%0d/%0d want=0000/0/0", bus.rd_sdram_req, bus.wr_sdram_req, err_timeout, wr_done, bus.rd_addr, bus.wr_addr); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_no_init();
    test_first_write();
    test_read_priority();
    test_frame_write();
    test_read_wrap();
    test_frame_sync();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_req_arb.md
Name: sdram_req_arb

Overview:
- Upstream request arbiter for the SDRAM controller.
- Watches the write FIFO (ROM image source) and the read FIFO (VGA sink), and decides which full-page burst to request next.
- Drives exactly one of wr_sdram_req / rd_sdram_req at a time and holds it until the controller's single-cycle ack.
- Tracks per-burst write/read addresses over one frame buffer.

Parameters:
- BURST_LEN, 512, words per burst (one full page); also the FIFO level threshold.
- FIFO_AW, 10, FIFO used-word count width (depth 2^FIFO_AW = 1024).
- FRAME_BURSTS, 600, bursts per frame (640x480 / 512).
- ADDR_W, 15, burst address width, {bank[1:0], row[12:0]}.
- GAP_CYC, 16, idle cycles enforced after each ack before the next request.
- TIMEOUT, 4095, cycles a request may wait for ack before abort.

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller.
- rst  in  1  asynchronous reset, active-high.
- init_done  in  1  SDRAM initialisation complete (level).
- wr_fifo_usedw  in  FIFO_AW+1  words currently in the write FIFO.
- rd_fifo_usedw  in  FIFO_AW+1  words currently in the read FIFO.
- frame_sync  in  1  one-cycle pulse at display frame start.
- wr_sdram_ack  in  1  one-cycle pulse: write burst finished.
- rd_sdram_ack  in  1  one-cycle pulse: read burst finished.
- wr_sdram_req  out  1  write burst request (level, held until ack).
- rd_sdram_req  out  1  read burst request (level, held until ack).
- wr_addr  out  ADDR_W  burst address for the current or next write.
- rd_addr  out  ADDR_W  burst address for the current or next read.
- wr_done  out  1  sticky: whole frame written.
- err_timeout  out  1  sticky: an ack timeout occurred.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; wr_cnt, rd_cnt, gap and timeout counters 0. rst asserted mid-burst drops the request immediately; the controller finishes its burst on its own.
- Eligibility, evaluated in IDLE only:
  - wr_ok = init_done & ~wr_done & (wr_fifo_usedw >= BURST_LEN)
  - rd_ok = init_done & (rd_fifo_usedw <= 2^FIFO_AW - BURST_LEN) & (wr_done | rd_addr < wr_addr)
- States:
  - IDLE:
    - rd_ok -> RD_BUSY, rd_sdram_req=1 from the next cycle.
    - else wr_ok -> WR_BUSY, wr_sdram_req=1 from the next cycle.
    - Read wins when both are eligible, so the display never starves.
  - WR_BUSY:
    - wr_sdram_ack -> req=0 next cycle.
    - wr_addr increments; if wr_addr was FRAME_BURSTS-1 it becomes 0 and wr_done is set.
    - Go to GAP.
  - RD_BUSY:
    - rd_sdram_ack -> req=0 next cycle.
    - rd_addr increments, wrapping FRAME_BURSTS-1 -> 0.
    - Go to GAP.
  - GAP: count GAP_CYC cycles with both requests low, then go to IDLE. This guarantees both requests are low before the controller re-enters its idle state.
- Requests are registered outputs and are never both high in any cycle.
- Timeout: a counter runs during each BUSY state. On reaching TIMEOUT with no ack:
  - drop the request and set err_timeout;
  - leave the address unchanged so the burst is retried;
  - go to GAP.
- An ack of the wrong type is ignored: no address change, no state change.
- frame_sync:
  - Outside RD_BUSY: rd_addr <= 0 that cycle.
  - In RD_BUSY: a pending flag is set; at the ack, rd_addr <= 0 instead of incrementing.
  - frame_sync coinciding with rd_sdram_ack: rd_addr <= 0 (reset wins).
- init_done falling: the current burst completes normally; no new requests are issued.
- Write/read pointers are plain binary; the comparison rd_addr < wr_addr is unsigned at ADDR_W bits.

Test Plan:
- init_done=0 with wr_fifo_usedw=1024 -> no request for 10000 cycles.
- init_done=1, wr_fifo_usedw=512, rd_fifo_usedw=0 -> wr_sdram_req=1 (rd_ok false because rd_addr==wr_addr==0). Ack -> req low next cycle, wr_addr=1, next request no earlier than 17 cycles after the ack.
- wr_addr=5, rd_addr=2, wr_fifo_usedw=600, rd_fifo_usedw=100 -> rd_sdram_req wins. Ack -> rd_addr=3; write is issued after GAP.
- Drive 600 write bursts with auto-ack -> wr_done=1 after the 600th ack, wr_addr=0, no further wr_sdram_req.
- rd_addr=599 with an ack -> rd_addr=0. frame_sync during RD_BUSY with rd_addr=40 -> rd_addr=0 at ack, not 41.
- Request with no ack -> req drops at cycle 4095, err_timeout=1, address unchanged, re-request after GAP. rst pulse -> all outputs 0 asynchronously.
